// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
// Module      : execute_stage
// Description : MIPS execute stage. Single-cycle ALU, iterative 32-step
//               multiplier/divider owning HI/LO, and a single-entry output
//               register with a valid/ready handshake toward memory.
// Revision    : 1.0 - initial release
// ============================================================================
module execute_stage #(
  parameter int XLEN        = 32,
  parameter int ITER_CYCLES = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_srca,
  input  logic [XLEN-1:0] in_srcb,
  input  logic [4:0]      in_shamt,
  input  logic [4:0]      in_alu_op,
  input  logic [4:0]      in_rd,
  input  logic            in_reg_write,
  input  logic            in_mem_to_reg,
  input  logic            in_mem_write,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_alu_result,
  output logic [XLEN-1:0] out_store_data,
  output logic [4:0]      out_rd,
  output logic            out_reg_write,
  output logic            out_mem_to_reg,
  output logic            out_mem_write,
  output logic            busy
);

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_AND   = 5'd2;
  localparam logic [4:0] OP_OR    = 5'd3;
  localparam logic [4:0] OP_XOR   = 5'd4;
  localparam logic [4:0] OP_NOR   = 5'd5;
  localparam logic [4:0] OP_SLT   = 5'd6;
  localparam logic [4:0] OP_SLTU  = 5'd7;
  localparam logic [4:0] OP_SLL   = 5'd8;
  localparam logic [4:0] OP_SRL   = 5'd9;
  localparam logic [4:0] OP_SRA   = 5'd10;
  localparam logic [4:0] OP_SLLV  = 5'd11;
  localparam logic [4:0] OP_SRLV  = 5'd12;
  localparam logic [4:0] OP_SRAV  = 5'd13;
  localparam logic [4:0] OP_LUI   = 5'd14;
  localparam logic [4:0] OP_MFHI  = 5'd15;
  localparam logic [4:0] OP_MFLO  = 5'd16;
  localparam logic [4:0] OP_MTHI  = 5'd17;
  localparam logic [4:0] OP_MTLO  = 5'd18;
  localparam logic [4:0] OP_MULT  = 5'd19;
  localparam logic [4:0] OP_MULTU = 5'd20;
  localparam logic [4:0] OP_DIV   = 5'd21;
  localparam logic [4:0] OP_DIVU  = 5'd22;

  localparam logic [4:0] LAST_ITER = 5'(ITER_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  logic [4:0]        count;
  logic [XLEN-1:0]   hi;
  logic [XLEN-1:0]   lo;
  logic [2*XLEN-1:0] acc;        // product, or {remainder, quotient}
  logic [XLEN-1:0]   md_b;       // multiplicand / divisor magnitude
  logic [XLEN-1:0]   md_srca;    // raw dividend, returned in HI on divide by zero
  logic              md_is_div;
  logic              md_neg_lo;  // negate product / quotient
  logic              md_neg_hi;  // negate remainder
  logic              md_div_zero;

  logic              accept;
  logic              is_md;
  logic              is_signed_md;
  logic              neg_a;
  logic              neg_b;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN-1:0]   alu_result;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] acc_next;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   fin_hi;
  logic [XLEN-1:0]   fin_lo;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  assign is_md        = (in_alu_op == OP_MULT) || (in_alu_op == OP_MULTU) ||
                        (in_alu_op == OP_DIV)  || (in_alu_op == OP_DIVU);
  assign is_signed_md = (in_alu_op == OP_MULT) || (in_alu_op == OP_DIV);
  assign neg_a        = is_signed_md && in_srca[XLEN-1];
  assign neg_b        = is_signed_md && in_srcb[XLEN-1];
  assign mag_a        = neg_a ? (~in_srca + 1'b1) : in_srca;
  assign mag_b        = neg_b ? (~in_srcb + 1'b1) : in_srcb;

  // Single-cycle ALU result for the op presented by decode
  always_comb begin
    alu_result = '0;
    case (in_alu_op)
      OP_ADD:  alu_result = in_srca + in_srcb;
      OP_SUB:  alu_result = in_srca - in_srcb;
      OP_AND:  alu_result = in_srca & in_srcb;
      OP_OR:   alu_result = in_srca | in_srcb;
      OP_XOR:  alu_result = in_srca ^ in_srcb;
      OP_NOR:  alu_result = ~(in_srca | in_srcb);
      OP_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(in_srca) < $signed(in_srcb))};
      OP_SLTU: alu_result = {{(XLEN-1){1'b0}}, (in_srca < in_srcb)};
      OP_SLL:  alu_result = in_srcb << in_shamt;
      OP_SRL:  alu_result = in_srcb >> in_shamt;
      OP_SRA:  alu_result = $unsigned($signed(in_srcb) >>> in_shamt);
      OP_SLLV: alu_result = in_srcb << in_srca[4:0];
      OP_SRLV: alu_result = in_srcb >> in_srca[4:0];
      OP_SRAV: alu_result = $unsigned($signed(in_srcb) >>> in_srca[4:0]);
      OP_LUI:  alu_result = {in_srcb[15:0], 16'h0000};
      OP_MFHI: alu_result = hi;
      OP_MFLO: alu_result = lo;
      default: alu_result = '0;
    endcase
  end

  // One shift-add or restoring-subtract iteration on the accumulator
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, md_b} : {(XLEN+1){1'b0}});
    div_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, md_b};
    if (state == MUL) begin
      acc_next = {mul_sum, acc[XLEN-1:1]};
    end else if (!div_diff[XLEN]) begin
      acc_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      acc_next = {acc[2*XLEN-2:0], 1'b0};
    end
  end

  // Sign fixup and divide-by-zero override of the final HI/LO
  always_comb begin
    prod_fix = md_neg_lo ? (~acc + 1'b1) : acc;
    fin_hi   = prod_fix[2*XLEN-1:XLEN];
    fin_lo   = prod_fix[XLEN-1:0];
    if (md_is_div) begin
      if (md_div_zero) begin
        fin_hi = md_srca;
        fin_lo = '1;
      end else begin
        fin_hi = md_neg_hi ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
        fin_lo = md_neg_lo ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
      end
    end
  end

  // Stage FSM, HI/LO and the output payload register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      count          <= '0;
      busy           <= 1'b0;
      hi             <= '0;
      lo             <= '0;
      acc            <= '0;
      md_b           <= '0;
      md_srca        <= '0;
      md_is_div      <= 1'b0;
      md_neg_lo      <= 1'b0;
      md_neg_hi      <= 1'b0;
      md_div_zero    <= 1'b0;
      out_valid      <= 1'b0;
      out_pc         <= '0;
      out_instr      <= '0;
      out_alu_result <= '0;
      out_store_data <= '0;
      out_rd         <= '0;
      out_reg_write  <= 1'b0;
      out_mem_to_reg <= 1'b0;
      out_mem_write  <= 1'b0;
    end else if (flush) begin
      // Kill the buffered payload and any multiply/divide in progress
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            out_pc         <= in_pc;
            out_instr      <= in_instr;
            out_store_data <= in_srcb;
            out_rd         <= in_rd;
            out_mem_to_reg <= in_mem_to_reg;
            out_mem_write  <= in_mem_write;
            if (is_md) begin
              // Passthrough fields are parked now; result and valid follow at completion
              out_reg_write <= 1'b0;
              md_is_div     <= (in_alu_op == OP_DIV) || (in_alu_op == OP_DIVU);
              md_neg_lo     <= neg_a ^ neg_b;
              md_neg_hi     <= neg_a;
              md_div_zero   <= (in_srcb == '0);
              md_srca       <= in_srca;
              md_b          <= mag_b;
              acc           <= {{XLEN{1'b0}}, mag_a};
              count         <= '0;
              busy          <= 1'b1;
              state         <= ((in_alu_op == OP_DIV) || (in_alu_op == OP_DIVU)) ? DIV : MUL;
            end else begin
              out_reg_write  <= in_reg_write;
              out_alu_result <= alu_result;
              out_valid      <= 1'b1;
              if (in_alu_op == OP_MTHI) hi <= in_srca;
              if (in_alu_op == OP_MTLO) lo <= in_srca;
            end
          end
        end
        MUL, DIV: begin
          acc   <= acc_next;
          count <= count + 5'd1;
          if (count == LAST_ITER) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (!out_valid || out_ready) begin
            hi             <= fin_hi;
            lo             <= fin_lo;
            out_alu_result <= fin_lo;
            out_valid      <= 1'b1;
            busy           <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_execute_stage
// Description : Self-checking bench for execute_stage: ALU vector table,
//               scoreboard on the memory-side handshake, hand-written
//               stall / multiply / divide / flush / reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_stage;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic [31:0] in_srca;
  logic [31:0] in_srcb;
  logic [4:0]  in_shamt;
  logic [4:0]  in_alu_op;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        in_mem_to_reg;
  logic        in_mem_write;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] out_alu_result;
  logic [31:0] out_store_data;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        out_mem_to_reg;
  logic        out_mem_write;
  logic        busy;

  execute_stage #(.XLEN(32), .ITER_CYCLES(32)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_srca(in_srca), .in_srcb(in_srcb),
    .in_shamt(in_shamt), .in_alu_op(in_alu_op), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg), .in_mem_write(in_mem_write),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_alu_result(out_alu_result),
    .out_store_data(out_store_data), .out_rd(out_rd), .out_reg_write(out_reg_write),
    .out_mem_to_reg(out_mem_to_reg), .out_mem_write(out_mem_write), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] store;
    logic [31:0] result;
    logic        reg_write;
    bit          chk_res;
  } exp_t;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;

  exp_t        sb[$];
  int          checks = 0;
  int          fails  = 0;
  logic [31:0] pc_ctr = 32'h0000_1000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: a payload is consumed at the next edge whenever valid && ready here
  always @(negedge clk) begin
    if (resetn && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_payload", out_pc, 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("payload_pc", out_pc, e.pc);
        chk("payload_store_data", out_store_data, e.store);
        chk("payload_reg_write", {31'h0, out_reg_write}, {31'h0, e.reg_write});
        if (e.chk_res) chk("payload_result", out_alu_result, e.result);
      end
    end
  end

  // Present one instruction (called just after a rising edge) and hold it until accepted
  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] sh, input logic [31:0] exp, input bit chk_res,
                      input bit push);
    exp_t e;
    bit   md;
    int   waited;
    md = (op >= 5'd19) && (op <= 5'd22);
    pc_ctr        = pc_ctr + 32'd4;
    in_valid      = 1'b1;
    in_pc         = pc_ctr;
    in_instr      = {27'h0, op};
    in_srca       = a;
    in_srcb       = b;
    in_shamt      = sh;
    in_alu_op     = op;
    in_rd         = op;
    in_reg_write  = 1'b1;
    in_mem_to_reg = 1'b0;
    in_mem_write  = 1'b0;
    if (push) begin
      e.pc        = pc_ctr;
      e.store     = b;
      e.result    = exp;
      e.reg_write = !md;
      e.chk_res   = chk_res;
      sb.push_back(e);
    end
    waited = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 200) break;
    end
    if (waited > 200) begin
      chk("accept_timeout", 32'(waited), 32'd0);
    end else begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Run a multiply/divide, measure busy length, then read HI and LO back
  task automatic run_md(input string name, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cnt;
    send(op, a, b, 5'd0, 32'h0, 1'b0, 1'b1);
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!busy || cnt > 100) break;
      cnt++;
    end
    chk({name, "_busy_cycles"}, 32'(cnt), 32'd33);
    @(posedge clk);
    #1;
    send(5'd15, 32'h0, 32'h0, 5'd0, exp_hi, 1'b1, 1'b1);
    send(5'd16, 32'h0, 32'h0, 5'd0, exp_lo, 1'b1, 1'b1);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  vec_t vecs[17];

  initial begin
    vecs[0]  = '{5'd0,  32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000};
    vecs[1]  = '{5'd1,  32'h0000_0000, 32'h0000_0001, 5'd0,  32'hFFFF_FFFF};
    vecs[2]  = '{5'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'hF000_F000};
    vecs[3]  = '{5'd3,  32'hF0F0_F0F0, 32'h0F00_000F, 5'd0,  32'hFFF0_F0FF};
    vecs[4]  = '{5'd4,  32'hFFFF_0000, 32'hF0F0_F0F0, 5'd0,  32'h0F0F_F0F0};
    vecs[5]  = '{5'd5,  32'hF0F0_0000, 32'h0000_000F, 5'd0,  32'h0F0F_FFF0};
    vecs[6]  = '{5'd6,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0001};
    vecs[7]  = '{5'd7,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000};
    vecs[8]  = '{5'd8,  32'h0000_0000, 32'h0000_0001, 5'd4,  32'h0000_0010};
    vecs[9]  = '{5'd9,  32'h0000_0000, 32'h8000_0000, 5'd31, 32'h0000_0001};
    vecs[10] = '{5'd10, 32'h0000_0000, 32'h8000_0000, 5'd4,  32'hF800_0000};
    vecs[11] = '{5'd11, 32'h0000_0024, 32'h0000_0001, 5'd0,  32'h0000_0010};
    vecs[12] = '{5'd12, 32'h0000_0001, 32'h8000_0000, 5'd7,  32'h4000_0000};
    vecs[13] = '{5'd13, 32'h0000_0008, 32'h8000_0000, 5'd0,  32'hFF80_0000};
    vecs[14] = '{5'd14, 32'h0000_0000, 32'hABCD_1234, 5'd0,  32'h1234_0000};
    vecs[15] = '{5'd31, 32'h1234_5678, 32'h1111_1111, 5'd0,  32'h0000_0000};
    vecs[16] = '{5'd0,  32'hFFFF_FFFF, 32'h0000_0002, 5'd0,  32'h0000_0001};

    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_instr = '0; in_srca = '0; in_srcb = '0; in_shamt = '0;
    in_alu_op = '0; in_rd = '0; in_reg_write = 1'b0; in_mem_to_reg = 1'b0; in_mem_write = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // Reset state
    @(negedge clk);
    chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_in_ready", {31'h0, in_ready}, 32'h1);
    chk("reset_result", out_alu_result, 32'h0);
    @(posedge clk);
    #1;

    // ALU vector table, back-to-back with the memory stage always ready
    for (int i = 0; i < 17; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].exp, 1'b1, 1'b1);
    end
    settle(2);

    // Stall: first payload held, decode blocked, then drained with no bubble
    out_ready = 1'b0;
    send(5'd0, 32'd1, 32'd2, 5'd0, 32'd3, 1'b1, 1'b1);
    fork
      send(5'd0, 32'd10, 32'd20, 5'd0, 32'd30, 1'b1, 1'b1);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("stall_out_valid", {31'h0, out_valid}, 32'h1);
          chk("stall_held_result", out_alu_result, 32'd3);
          chk("stall_in_ready", {31'h0, in_ready}, 32'h0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("no_bubble_valid", {31'h0, out_valid}, 32'h1);
        chk("no_bubble_result", out_alu_result, 32'd30);
      end
    join
    settle(2);

    // Multiply / divide through HI/LO
    run_md("mult",  5'd19, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_md("multu", 5'd20, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_md("div",   5'd21, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("divu0", 5'd22, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF);
    run_md("divov", 5'd21, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_md("divu",  5'd22, 32'd100,       32'd7,         32'd2,         32'd14);
    settle(2);

    // Flush at iteration 10 of MULTU 3x5 leaves HI/LO untouched
    send(5'd17, 32'h11, 32'h0, 5'd0, 32'h0, 1'b0, 1'b1);
    send(5'd18, 32'h11, 32'h0, 5'd0, 32'h0, 1'b0, 1'b1);
    send(5'd20, 32'd3, 32'd5, 5'd0, 32'h0, 1'b0, 1'b0);
    settle(9);
    @(negedge clk);
    chk("flush_pre_busy", {31'h0, busy}, 32'h1);
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", {31'h0, busy}, 32'h0);
    chk("flush_out_valid", {31'h0, out_valid}, 32'h0);
    chk("flush_in_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk);
    #1;
    send(5'd0, 32'd40, 32'd2, 5'd0, 32'd42, 1'b1, 1'b1);
    send(5'd15, 32'h0, 32'h0, 5'd0, 32'h11, 1'b1, 1'b1);
    send(5'd16, 32'h0, 32'h0, 5'd0, 32'h11, 1'b1, 1'b1);
    settle(2);

    // Asynchronous reset in the middle of a DIVU
    send(5'd22, 32'd100, 32'd7, 5'd0, 32'h0, 1'b0, 1'b0);
    settle(5);
    chk("rst_pre_busy", {31'h0, busy}, 32'h1);
    #3 resetn = 1'b0;
    #1;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_store", out_store_data, 32'h0);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk);
    #1;
    send(5'd15, 32'h0, 32'h0, 5'd0, 32'h0, 1'b1, 1'b1);
    send(5'd16, 32'h0, 32'h0, 5'd0, 32'h0, 1'b1, 1'b1);
    settle(3);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
